axi4_lite_regfile: RTL and testbench

Parametrised AXI4-Lite slave register file for the AXI4_Lite subsystem. It exposes NUM_REGS registers of DATA_W bits to a single AXI4-Lite master and provides full VALID/READY handshaking on all five channels. Features:
- Independent AW/W acceptance.
- WSTRB byte enables.
- BVALID/RVALID held until accepted.
- SLVERR on out-of-range or read-only writes.
- Read-only status registers fed from fabric.

---
 rtl/axi4_lite_pkg.sv | 21 ++
 rtl/axi4_lite_hold_buf.sv | 55 +++++
 rtl/axi4_lite_regfile.sv | 184 ++++++++++++++++++
 tb/tb_axi4_lite_regfile.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_lite_pkg
//  Brief    : Shared response codes and address decode helper for the
//             AXI4-Lite register file.
//  Revision : 1.0  initial release
// ============================================================================
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Drop the byte-offset bits of an address to get a register index.
  // Only 32- and 64-bit data widths are supported, so the shift is 2 or 3.
  function automatic logic [63:0] addr_to_idx(input logic [63:0] addr,
                                              input int unsigned data_w);
    return (data_w == 64) ? (addr >> 3) : (addr >> 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi4_lite_hold_buf.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_lite_hold_buf
//  Brief    : One-entry valid/ready holding register. Accepts a beat when
//             empty and enabled, holds it until the consumer clears it.
//  Revision : 1.0  initial release
// ============================================================================
module axi4_lite_hold_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic             enable,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clear,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  assign in_ready = enable & ~full_q;
  assign full     = full_q;
  assign data     = data_q;

  // Next state: a clear only happens while full and a load only while empty,
  // so the two never compete in the same cycle.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (clear) begin
      full_d = 1'b0;
    end
    if (in_valid && in_ready) begin
      full_d = 1'b1;
      data_d = in_data;
    end
  end

  // Buffer state flops.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi4_lite_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_lite_regfile
//  Brief    : AXI4-Lite slave register file with byte strobes, SLVERR on
//             out-of-range / read-only writes and fabric-fed status regs.
//  Revision : 1.0  initial release
// ============================================================================
module axi4_lite_regfile
  import axi4_lite_pkg::*;
#(
  parameter int unsigned          DATA_W   = 32,
  parameter int unsigned          ADDR_W   = 8,
  parameter int unsigned          NUM_REGS = 8,
  parameter logic [NUM_REGS-1:0]  RO_MASK  = '0
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,
  input  logic [ADDR_W-1:0]            AWADDR,
  input  logic                         AWVALID,
  output logic                         AWREADY,
  input  logic [DATA_W-1:0]            WDATA,
  input  logic [DATA_W/8-1:0]          WSTRB,
  input  logic                         WVALID,
  output logic                         WREADY,
  output logic [1:0]                   BRESP,
  output logic                         BVALID,
  input  logic                         BREADY,
  input  logic [ADDR_W-1:0]            ARADDR,
  input  logic                         ARVALID,
  output logic                         ARREADY,
  output logic [DATA_W-1:0]            RDATA,
  output logic [1:0]                   RRESP,
  output logic                         RVALID,
  input  logic                         RREADY,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  input  logic [NUM_REGS*DATA_W-1:0]   reg_in,
  output logic [NUM_REGS-1:0]          reg_wr_stb
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic                             rst_done_q, rst_done_d;
  logic [NUM_REGS-1:0][DATA_W-1:0]  regs_q, regs_d;
  logic [NUM_REGS-1:0][DATA_W-1:0]  reg_in_arr;
  logic [NUM_REGS-1:0]              reg_wr_stb_q, reg_wr_stb_d;
  logic                             bvalid_q, bvalid_d;
  logic [1:0]                       bresp_q, bresp_d;
  logic                             rvalid_q, rvalid_d;
  logic [1:0]                       rresp_q, rresp_d;
  logic [DATA_W-1:0]                rdata_q, rdata_d;

  logic                             aw_full, w_full, commit;
  logic [ADDR_W-1:0]                aw_addr;
  logic [DATA_W-1:0]                w_data;
  logic [STRB_W-1:0]                w_strb;
  logic [63:0]                      aw_idx, ar_idx;
  logic [IDX_W-1:0]                 aw_sel, ar_sel;
  logic                             aw_writable, ar_in_range, ar_fire;

  assign reg_in_arr = reg_in;

  // Write address and write data are buffered independently so either may
  // arrive first; the commit consumes both together.
  axi4_lite_hold_buf #(.WIDTH(ADDR_W)) u_aw_buf (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .enable   (rst_done_q),
    .in_data  (AWADDR),
    .in_valid (AWVALID),
    .in_ready (AWREADY),
    .clear    (commit),
    .full     (aw_full),
    .data     (aw_addr)
  );

  axi4_lite_hold_buf #(.WIDTH(DATA_W + STRB_W)) u_w_buf (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .enable   (rst_done_q),
    .in_data  ({WSTRB, WDATA}),
    .in_valid (WVALID),
    .in_ready (WREADY),
    .clear    (commit),
    .full     (w_full),
    .data     ({w_strb, w_data})
  );

  assign commit      = aw_full & w_full & ~bvalid_q;
  assign aw_idx      = addr_to_idx(64'(aw_addr), DATA_W);
  assign aw_sel      = aw_idx[IDX_W-1:0];
  assign aw_writable = (aw_idx < 64'(NUM_REGS)) && !RO_MASK[aw_sel];

  assign ARREADY     = rst_done_q & ~rvalid_q;
  assign ar_fire     = ARVALID & ARREADY;
  assign ar_idx      = addr_to_idx(64'(ARADDR), DATA_W);
  assign ar_sel      = ar_idx[IDX_W-1:0];
  assign ar_in_range = ar_idx < 64'(NUM_REGS);

  assign BVALID     = bvalid_q;
  assign BRESP      = bresp_q;
  assign RVALID     = rvalid_q;
  assign RRESP      = rresp_q;
  assign RDATA      = rdata_q;
  assign reg_wr_stb = reg_wr_stb_q;

  // Read-only registers present their fabric input; the rest show storage.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
    if (RO_MASK[i]) begin : g_ro
      assign reg_q[i*DATA_W +: DATA_W] = reg_in_arr[i];
    end else begin : g_rw
      assign reg_q[i*DATA_W +: DATA_W] = regs_q[i];
    end
  end

  // Write commit: byte-lane update, strobe pulse and response generation.
  always_comb begin
    rst_done_d   = 1'b1;
    regs_d       = regs_q;
    reg_wr_stb_d = '0;
    bvalid_d     = bvalid_q;
    bresp_d      = bresp_q;
    if (commit) begin
      bvalid_d = 1'b1;
      if (aw_writable) begin
        bresp_d              = RESP_OKAY;
        reg_wr_stb_d[aw_sel] = 1'b1;
        for (int b = 0; b < STRB_W; b++) begin
          if (w_strb[b]) begin
            regs_d[aw_sel][b*8 +: 8] = w_data[b*8 +: 8];
          end
        end
      end else begin
        bresp_d = RESP_SLVERR;
      end
    end else if (bvalid_q && BREADY) begin
      bvalid_d = 1'b0;
    end
  end

  // Read capture: samples storage before any same-edge commit lands.
  always_comb begin
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (ar_fire) begin
      rvalid_d = 1'b1;
      if (ar_in_range) begin
        rresp_d = RESP_OKAY;
        rdata_d = RO_MASK[ar_sel] ? reg_in_arr[ar_sel] : regs_q[ar_sel];
      end else begin
        rresp_d = RESP_SLVERR;
        rdata_d = '0;
      end
    end else if (rvalid_q && RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  // State flops for registers, responses and the post-reset ready gate.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rst_done_q   <= 1'b0;
      regs_q       <= '0;
      reg_wr_stb_q <= '0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      rvalid_q     <= 1'b0;
      rresp_q      <= RESP_OKAY;
      rdata_q      <= '0;
    end else begin
      rst_done_q   <= rst_done_d;
      regs_q       <= regs_d;
      reg_wr_stb_q <= reg_wr_stb_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      rvalid_q     <= rvalid_d;
      rresp_q      <= rresp_d;
      rdata_q      <= rdata_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi4_lite_regfile
//  Brief    : Self-checking bench for axi4_lite_regfile: directed scenarios
//             plus randomized traffic against an array-based register model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axi4_lite_regfile;

  localparam logic [7:0]  RO_MASK_TB = 8'h80;
  localparam logic [31:0] RO7_VAL    = 32'h5A5A0001;

  logic         ACLK, ARESETn;
  logic [7:0]   AWADDR, ARADDR;
  logic         AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic [31:0]  WDATA, RDATA;
  logic [3:0]   WSTRB;
  logic [1:0]   BRESP, RRESP;
  logic         ARVALID, ARREADY, RVALID, RREADY;
  logic [255:0] reg_q, reg_in;
  logic [7:0]   reg_wr_stb;

  logic [31:0]  model [8];
  int           n_total = 0;
  int           n_pass  = 0;

  axi4_lite_regfile #(
    .DATA_W(32), .ADDR_W(8), .NUM_REGS(8), .RO_MASK(RO_MASK_TB)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .reg_q(reg_q), .reg_in(reg_in), .reg_wr_stb(reg_wr_stb)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic logic [31:0] rq(input int i);
    return reg_q[i*32 +: 32];
  endfunction

  function automatic logic [31:0] exp_reg(input int i);
    return RO_MASK_TB[i] ? RO7_VAL : model[i];
  endfunction

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check_regs();
    for (int i = 0; i < 8; i++) chk($sformatf("reg_q[%0d]", i), rq(i), exp_reg(i));
  endtask

  // Present AW and W after independent start delays; return once both taken.
  task automatic send_aw_w(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int cyc = 0;
    while (!(aw_done && w_done) && cyc < 40) begin
      if (!aw_done && cyc >= aw_dly) begin AWADDR = addr; AWVALID = 1'b1; end
      if (!w_done && cyc >= w_dly) begin WDATA = data; WSTRB = strb; WVALID = 1'b1; end
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      step();
      if (aw_hs) begin aw_done = 1; AWVALID = 1'b0; end
      if (w_hs)  begin w_done = 1;  WVALID = 1'b0; end
      cyc++;
    end
    chk("aw_w_accepted", {aw_done, w_done}, 2'b11);
  endtask

  // Full write with BREADY=1: checks latency, response, strobe and contents.
  task automatic do_write(input logic [7:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly);
    int idx;
    logic [1:0] exp_resp;
    logic [7:0] exp_stb;
    idx = int'(addr >> 2);
    if (idx < 8 && !RO_MASK_TB[idx]) begin
      for (int b = 0; b < 4; b++) if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
      exp_resp = 2'b00;
      exp_stb  = 8'(1 << idx);
    end else begin
      exp_resp = 2'b10;
      exp_stb  = 8'h00;
    end
    send_aw_w(addr, data, strb, aw_dly, w_dly);
    chk("bvalid_early", BVALID, 1'b0);
    step();
    chk("bvalid", BVALID, 1'b1);
    chk("bresp", BRESP, exp_resp);
    chk("wr_stb", reg_wr_stb, exp_stb);
    step();
    chk("bvalid_clr", BVALID, 1'b0);
    chk("wr_stb_clr", reg_wr_stb, 8'h00);
    check_regs();
  endtask

  task automatic do_read(input logic [7:0] addr);
    int idx;
    bit hs = 0;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    idx = int'(addr >> 2);
    if (idx < 8) begin exp_data = exp_reg(idx); exp_resp = 2'b00; end
    else begin exp_data = 32'h0; exp_resp = 2'b10; end
    ARADDR = addr;
    ARVALID = 1'b1;
    for (int c = 0; c < 20 && !hs; c++) begin
      hs = ARREADY;
      step();
    end
    ARVALID = 1'b0;
    chk("ar_accepted", hs, 1'b1);
    chk("rvalid", RVALID, 1'b1);
    chk("rdata", RDATA, exp_data);
    chk("rresp", RRESP, exp_resp);
    step();
    chk("rvalid_clr", RVALID, 1'b0);
  endtask

  initial begin
    logic [31:0] old5;
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
    reg_in = '0;
    for (int i = 0; i < 7; i++) reg_in[i*32 +: 32] = $urandom;
    reg_in[7*32 +: 32] = RO7_VAL;
    ARESETn = 1'b0;
    AWADDR = '0; AWVALID = 0; WDATA = '0; WSTRB = '0; WVALID = 0;
    ARADDR = '0; ARVALID = 0; BREADY = 1'b1; RREADY = 1'b1;

    // Reset state and release.
    repeat (3) step();
    chk("rst_ready", {AWREADY, WREADY, ARREADY}, 3'b000);
    chk("rst_valid", {BVALID, RVALID}, 2'b00);
    chk("rst_resp", {BRESP, RRESP}, 4'h0);
    chk("rst_rdata", RDATA, 32'h0);
    chk("rst_stb", reg_wr_stb, 8'h00);
    ARESETn = 1'b1;
    #1;
    chk("ready_pre_edge", {AWREADY, WREADY, ARREADY}, 3'b000);
    step();
    chk("ready_post_edge", {AWREADY, WREADY, ARREADY}, 3'b111);
    check_regs();

    // Same-cycle AW/W, then W three cycles before AW, then AW first.
    do_write(8'h04, 32'hDEADBEEF, 4'hF, 0, 0);
    chk("reg1_deadbeef", rq(1), 32'hDEADBEEF);
    do_write(8'h04, 32'hCAFEF00D, 4'hF, 3, 0);
    do_write(8'h19, 32'h600D600D, 4'hF, 0, 2);

    // Partial byte strobes.
    do_write(8'h08, 32'h11223344, 4'hF, 0, 0);
    do_write(8'h08, 32'hAABBCCDD, 4'b0101, 0, 0);
    chk("reg2_partial", rq(2), 32'h11BB33DD);
    do_write(8'h14, 32'hFFFFFFFF, 4'h0, 0, 0);

    // Read-only and out-of-range accesses.
    do_write(8'h1C, 32'h12345678, 4'hF, 0, 0);
    do_read(8'h1C);
    do_read(8'h40);
    do_write(8'h40, 32'h87654321, 4'hF, 1, 0);

    // Write response backpressure with a second write queued behind it.
    BREADY = 1'b0;
    model[4] = 32'h44440004;
    send_aw_w(8'h10, 32'h44440004, 4'hF, 0, 0);
    step();
    chk("bp_bvalid", BVALID, 1'b1);
    chk("bp_stb4", reg_wr_stb, 8'h10);
    old5 = model[5];
    send_aw_w(8'h14, 32'h55550005, 4'hF, 0, 0);
    for (int k = 0; k < 4; k++) begin
      chk("bp_hold_bvalid", BVALID, 1'b1);
      chk("bp_hold_bresp", BRESP, 2'b00);
      chk("bp_hold_reg5", rq(5), old5);
      chk("bp_hold_stb", reg_wr_stb, 8'h00);
      step();
    end
    BREADY = 1'b1;
    step();
    chk("bp_bvalid_drop", BVALID, 1'b0);
    chk("bp_reg5_still_old", rq(5), old5);
    step();
    model[5] = 32'h55550005;
    chk("bp2_bvalid", BVALID, 1'b1);
    chk("bp2_bresp", BRESP, 2'b00);
    chk("bp2_reg5", rq(5), 32'h55550005);
    chk("bp2_stb5", reg_wr_stb, 8'h20);
    step();
    chk("bp2_bvalid_clr", BVALID, 1'b0);

    // Read data backpressure: data held, no second AR accepted.
    RREADY = 1'b0;
    ARADDR = 8'h10; ARVALID = 1'b1;
    step();
    ARADDR = 8'h14;
    for (int k = 0; k < 4; k++) begin
      chk("rbp_rvalid", RVALID, 1'b1);
      chk("rbp_rdata", RDATA, model[4]);
      chk("rbp_arready", ARREADY, 1'b0);
      step();
    end
    RREADY = 1'b1;
    step();
    chk("rbp_rvalid_drop", RVALID, 1'b0);
    chk("rbp_arready_back", ARREADY, 1'b1);
    step();
    ARVALID = 1'b0;
    chk("rbp2_rvalid", RVALID, 1'b1);
    chk("rbp2_rdata", RDATA, model[5]);
    step();
    chk("rbp2_rvalid_clr", RVALID, 1'b0);

    // Read capture and write commit to reg3 on the same edge.
    do_write(8'h0C, 32'h1, 4'hF, 0, 0);
    AWADDR = 8'h0C; AWVALID = 1'b1; WDATA = 32'h2; WSTRB = 4'hF; WVALID = 1'b1;
    step();
    AWVALID = 1'b0; WVALID = 1'b0;
    ARADDR = 8'h0C; ARVALID = 1'b1;
    step();
    ARVALID = 1'b0;
    model[3] = 32'h2;
    chk("col_bvalid", BVALID, 1'b1);
    chk("col_rvalid", RVALID, 1'b1);
    chk("col_rdata_old", RDATA, 32'h1);
    step();
    chk("col_clr", {BVALID, RVALID}, 2'b00);
    do_read(8'h0C);

    // Randomized mixed traffic.
    for (int n = 0; n < 60; n++) begin
      logic [7:0] a;
      a = 8'($urandom_range(0, 8'h4F));
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3), $urandom_range(0, 3));
      else
        do_read(a);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
